// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates three byte requesters onto one shared UART transmitter.
// Define UART_ARB_PRIO0_EN to give requester 0 absolute priority over a 1/2 round-robin.
module uart_tx_arb #(
    parameter logic [15:0] BUSY_WAIT = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [23:0] req_data,
    output logic [2:0]  req_ready,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_pluse,
    output logic [1:0]  grant_id,
    output logic        arb_busy,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        SEND       = 3'd2,
        WAIT_START = 3'd3,
        WAIT_DONE  = 3'd4
    } state_t;

    // A zero wait budget still gives the transmitter one cycle to respond.
    localparam logic [15:0] WAIT_LAST = (BUSY_WAIT == 16'd0) ? 16'd0 : BUSY_WAIT - 16'd1;
    localparam logic [1:0]  NO_GRANT  = 2'd3;

    state_t      state_r, state_s;
    logic [1:0]  last_winner_r, last_winner_s;
    logic [15:0] count_r, count_s;
    logic [7:0]  tx_data_s;
    logic        tx_pluse_s;
    logic [2:0]  req_ready_s;
    logic [1:0]  grant_id_s;
    logic        arb_busy_s;
    logic        timeout_err_s;
    logic        finish_s;
    logic [1:0]  pick_s;

    function automatic logic [7:0] byte_of(input logic [23:0] data, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_of = data[7:0];
            2'd1:    byte_of = data[15:8];
            2'd2:    byte_of = data[23:16];
            default: byte_of = 8'h00;
        endcase
    endfunction

`ifdef UART_ARB_PRIO0_EN
    logic last_hi_r, last_hi_s;  // 1 when requester 2 was the last of the 1/2 pair served

    function automatic logic [1:0] prio_pick(input logic [2:0] valid, input logic last_hi);
        if (valid[0]) begin
            prio_pick = 2'd0;
        end else if (valid[1] && (!valid[2] || last_hi)) begin
            prio_pick = 2'd1;
        end else if (valid[2]) begin
            prio_pick = 2'd2;
        end else begin
            prio_pick = NO_GRANT;
        end
    endfunction
`else
    function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
        case (last)
            2'd0:    rr_pick = valid[1] ? 2'd1 : (valid[2] ? 2'd2 : (valid[0] ? 2'd0 : NO_GRANT));
            2'd1:    rr_pick = valid[2] ? 2'd2 : (valid[0] ? 2'd0 : (valid[1] ? 2'd1 : NO_GRANT));
            default: rr_pick = valid[0] ? 2'd0 : (valid[1] ? 2'd1 : (valid[2] ? 2'd2 : NO_GRANT));
        endcase
    endfunction
`endif

    // Winner selection from the current request vector.
    always_comb begin
`ifdef UART_ARB_PRIO0_EN
        pick_s = prio_pick(req_valid, last_hi_r);
`else
        pick_s = rr_pick(req_valid, last_winner_r);
`endif
    end

    // Next state and next registered outputs.
    always_comb begin
        state_s       = state_r;
        tx_data_s     = tx_data;
        tx_pluse_s    = 1'b0;
        req_ready_s   = 3'b000;
        grant_id_s    = grant_id;
        timeout_err_s = 1'b0;
        last_winner_s = last_winner_r;
        count_s       = count_r;
        finish_s      = 1'b0;
`ifdef UART_ARB_PRIO0_EN
        last_hi_s     = last_hi_r;
`endif
        case (state_r)
            IDLE: begin
                if ((req_valid != 3'b000) && !tx_busy) begin
                    tx_data_s   = byte_of(req_data, pick_s);
                    grant_id_s  = pick_s;
                    req_ready_s = 3'b001 << pick_s;
                    state_s     = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                tx_pluse_s = 1'b1;
                state_s    = SEND;
            end
            SEND: begin
                count_s = 16'd0;
                state_s = WAIT_START;
            end
            WAIT_START: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (count_r == WAIT_LAST) begin
                    timeout_err_s = 1'b1;
                    finish_s      = 1'b1;
                    state_s       = IDLE;
                end else begin
                    count_s = count_r + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_id_s = NO_GRANT;
            end
        endcase

        // A dropped (timed-out) byte still counts as that requester's turn.
        if (finish_s) begin
            last_winner_s = grant_id;
            grant_id_s    = NO_GRANT;
`ifdef UART_ARB_PRIO0_EN
            if (grant_id == 2'd1) begin
                last_hi_s = 1'b0;
            end else if (grant_id == 2'd2) begin
                last_hi_s = 1'b1;
            end else begin
                last_hi_s = last_hi_r;
            end
`endif
        end else begin
            last_winner_s = last_winner_r;
        end

        arb_busy_s = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            tx_data       <= 8'h00;
            tx_pluse      <= 1'b0;
            req_ready     <= 3'b000;
            grant_id      <= NO_GRANT;
            arb_busy      <= 1'b0;
            timeout_err   <= 1'b0;
            last_winner_r <= 2'd2;
            count_r       <= 16'd0;
        end else begin
            state_r       <= state_s;
            tx_data       <= tx_data_s;
            tx_pluse      <= tx_pluse_s;
            req_ready     <= req_ready_s;
            grant_id      <= grant_id_s;
            arb_busy      <= arb_busy_s;
            timeout_err   <= timeout_err_s;
            last_winner_r <= last_winner_s;
            count_r       <= count_s;
        end
    end

`ifdef UART_ARB_PRIO0_EN
    // Fairness pointer between requesters 1 and 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_hi_r <= 1'b1;
        end else begin
            last_hi_r <= last_hi_s;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against a transaction-schedule reference model.
// Honors UART_ARB_PRIO0_EN the same way the design does.
module tb_uart_tx_arb;
    localparam logic [15:0] BW  = 16'd16;
    localparam int          BWI = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_pluse;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arb #(.BUSY_WAIT(BW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_busy(tx_busy), .tx_data(tx_data),
        .tx_pluse(tx_pluse), .grant_id(grant_id), .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Requester byte queues
    logic [7:0] fifo [3][8];
    int         cnt [3];

    // Reference schedule: every transfer is a grant edge plus a completion edge
    int         cyc;
    int         g_cyc, c_cyc, free_at, busy_lo, busy_hi, force_until;
    logic       tout;
    int         m_last, m_last12;
    logic [1:0] m_gid;
    logic [7:0] m_data;
    int         tx_mode;      // 0 random, 1 busy 20 cycles after 1, 2 never busy
    logic       push_rand, ext_rand;
    logic [7:0] obs [$];
    int         n_tout;

    task automatic push(input int r, input logic [7:0] b);
        if (cnt[r] < 8) begin
            fifo[r][cnt[r]] = b;
            cnt[r]++;
        end
    endtask

    task automatic pop(input int r);
        for (int k = 0; k < 7; k++) fifo[r][k] = fifo[r][k+1];
        cnt[r]--;
    endtask

    function automatic int pick(input logic [2:0] v);
`ifdef UART_ARB_PRIO0_EN
        if (v[0]) return 0;
        if (v[1] && v[2]) return (m_last12 == 1) ? 2 : 1;
        return v[1] ? 1 : 2;
`else
        for (int k = 1; k <= 3; k++) begin
            if (v[(m_last + k) % 3]) return (m_last + k) % 3;
        end
        return 3;
`endif
    endfunction

    task automatic model_reset();
        g_cyc = -100; c_cyc = -100; free_at = 0;
        busy_lo = -100; busy_hi = -200; force_until = 0;
        tout = 1'b0; m_last = 2; m_last12 = 2; m_gid = 2'd3; m_data = 8'h00;
    endtask

    // Inputs for edge number cyc
    task automatic drive_inputs();
        logic b;
        b = (cyc >= busy_lo) && (cyc <= busy_hi);
        if (cyc >= free_at) begin
            if (cyc < force_until) b = 1'b1;
            else if (ext_rand && $urandom_range(0, 7) == 0) b = 1'b1;
        end
        tx_busy = b;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = (cnt[i] != 0);
            req_data[8*i +: 8] = (cnt[i] != 0) ? fifo[i][0] : 8'($urandom);
        end
    endtask

    task automatic drive_next();
        if (push_rand && $urandom_range(0, 2) == 0) push($urandom_range(0, 2), 8'($urandom));
        drive_inputs();
    endtask

    // Decide whether edge cyc grants, and schedule the whole transfer if so.
    task automatic model_edge();
        int w, e, d, len;
        logic never;
        if (cyc >= free_at && req_valid != 3'b000 && !tx_busy) begin
            w = pick(req_valid);
            g_cyc = cyc; m_gid = 2'(w); m_data = fifo[w][0];
            pop(w);
            m_last = w;
            if (w != 0) m_last12 = w;
            e = cyc + 2;    // edge at which the transmitter first sees tx_pluse
            never = (tx_mode == 2) || (tx_mode == 0 && $urandom_range(0, 7) == 0);
            if (never) begin
                tout = 1'b1; busy_lo = -100; busy_hi = -200;
                c_cyc = e + BWI;
            end else begin
                d   = (tx_mode == 1) ? 1  : $urandom_range(1, BWI);
                len = (tx_mode == 1) ? 20 : $urandom_range(1, 6);
                tout = 1'b0; busy_lo = e + d; busy_hi = e + d + len - 1;
                c_cyc = e + d + len;
            end
            free_at = c_cyc + 1;
        end
    endtask

    task automatic run(input int n);
        logic [2:0] er;
        logic       ep, ea, et;
        logic [1:0] eg;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            er = (cyc == g_cyc) ? (3'b001 << m_gid) : 3'b000;
            ep = (cyc == g_cyc + 1);
            et = tout && (cyc == c_cyc);
            ea = (cyc >= g_cyc) && (cyc < c_cyc);
            eg = ea ? m_gid : 2'd3;
            check_eq($sformatf("outs@%0d", cyc),
                     {16'h0000, req_ready, tx_pluse, grant_id, arb_busy, timeout_err, tx_data},
                     {16'h0000, er, ep, eg, ea, et, m_data});
            if (tx_pluse) obs.push_back(tx_data);
            if (timeout_err) n_tout++;
            cyc++;
            drive_next();
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, {16'h0000, req_ready, tx_pluse, grant_id, arb_busy, timeout_err, tx_data},
                 {16'h0000, 3'b000, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00});
    endtask

    logic [7:0] exp_seq [4];
    int         base, tbase;

    initial begin
        rst = 1'b1; req_valid = 3'b000; req_data = 24'h0; tx_busy = 1'b0;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        cyc = 0; n_tout = 0; tx_mode = 1; push_rand = 1'b0; ext_rand = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst = 1'b0;

        // Three requesters always valid, transmitter busy 20 cycles per byte
        for (int k = 0; k < 4; k++) push(0, 8'h41);
        for (int k = 0; k < 2; k++) begin push(1, 8'h42); push(2, 8'h43); end
        drive_inputs();
`ifdef UART_ARB_PRIO0_EN
        exp_seq = '{8'h41, 8'h41, 8'h41, 8'h41};
`else
        exp_seq = '{8'h41, 8'h42, 8'h43, 8'h41};
`endif
        base = obs.size();
        run(110);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("seq%0d", k),
                     (obs.size() > base + k) ? 32'(obs[base + k]) : 32'hFFFF_FFFF, 32'(exp_seq[k]));
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        drive_inputs();
        run(40);

        // Single one-cycle request from requester 1
        tx_mode = 0;
        base = obs.size();
        push(1, 8'h5A);
        drive_inputs();
        run(40);
        check_eq("single_cnt", 32'(obs.size() - base), 32'd1);
        check_eq("single_byte", 32'(obs[obs.size() - 1]), 32'h5A);

        // Transmitter held busy by someone else while requester 0 waits
        tx_mode = 1;
        force_until = cyc + 10;
        push(0, 8'h77);
        drive_inputs();
        run(50);
        check_eq("held_byte", 32'(obs[obs.size() - 1]), 32'h77);

        // Transmitter never responds: both bytes time out and are dropped
        tx_mode = 2;
        tbase = n_tout;
        push(1, 8'hB1); push(2, 8'hB2);
        drive_inputs();
        run(60);
        check_eq("timeouts", 32'(n_tout - tbase), 32'd2);

        // Reset while the transmitter is sending
        tx_mode = 1;
        push(0, 8'hC3);
        drive_inputs();
        run(10);
        rst = 1'b1;
        cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
        drive_inputs();
        tx_busy = 1'b0;
        #1;
        check_reset_outs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive_inputs();
        base = obs.size();
        run(20);
        check_eq("quiet_after_rst", 32'(obs.size() - base), 32'd0);
        push(2, 8'h22); push(0, 8'h11);
        drive_inputs();
        run(40);
        check_eq("first_after_rst",
                 (obs.size() > base) ? 32'(obs[base]) : 32'hFFFF_FFFF, 32'h11);

        // Random traffic
        tx_mode = 0; push_rand = 1'b1; ext_rand = 1'b1;
        run(2500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
